// File: rtl/lsu_split_pkg.sv
// Shared definitions for the load/store unit.
//   - access size encodings (log2 of the byte count)
//   - FSM state enum
//   - lane helpers sized for the widest supported bus (64 bits, 8 lanes);
//     callers truncate the results to their own bus width.
package lsu_split_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_RESP  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // One bit per byte of the access, starting at lane 0.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Byte mask placed at the lane offset across two consecutive bus words:
  // the low STRB_W bits are the first beat, the next STRB_W bits the second.
  function automatic logic [15:0] lane_strobes(input logic [2:0] off, input logic [1:0] size);
    return {8'h00, size_byte_mask(size)} << off;
  endfunction

endpackage

// File: rtl/lsu_split_align.sv
// Combinational lane steering for lsu_split.
//   off/size/wdata -> straddle flag, beat0/beat1 strobes and shifted write data
//   b0/b1/sext     -> load data merged from both beats, masked to the access
//                     size and sign- or zero-extended to DATA_W.
module lsu_align
  import lsu_split_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          off,
  input  logic [1:0]          size,
  input  logic                sext,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   b0,
  input  logic [DATA_W-1:0]   b1,
  output logic                straddle,
  output logic [DATA_W/8-1:0] strb0,
  output logic [DATA_W/8-1:0] strb1,
  output logic [DATA_W-1:0]   wdata0,
  output logic [DATA_W-1:0]   wdata1,
  output logic [DATA_W-1:0]   rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [15:0]         strb_all;
  logic [4:0]          end_byte;
  logic [2*DATA_W-1:0] w_wide;
  logic [DATA_W-1:0]   r_shift;
  logic [7:0]          bm8;
  logic [STRB_W-1:0]   bm;
  logic [DATA_W-1:0]   bit_mask;
  logic [DATA_W-1:0]   top_mask;

  always_comb begin
    strb_all = lane_strobes(off, size);
    strb0    = STRB_W'(strb_all);
    strb1    = STRB_W'(strb_all >> STRB_W);

    end_byte = {2'b00, off} + {1'b0, size_bytes(size)};
    straddle = end_byte > 5'(STRB_W);

    // Shifting across a double-width word yields both beats at once: the
    // upper half is exactly wdata >> 8*(STRB_W-off).
    w_wide = {{DATA_W{1'b0}}, wdata} << (8 * off);
    wdata0 = w_wide[DATA_W-1:0];
    wdata1 = w_wide[2*DATA_W-1:DATA_W];

    // For a single-beat access the selected bytes never reach b1, so a stale
    // second beat cannot leak into the result.
    r_shift = DATA_W'({b1, b0} >> (8 * off));

    bm8 = size_byte_mask(size);
    bm  = STRB_W'(bm8);
    bit_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      bit_mask[8*i +: 8] = {8{bm[i]}};
    end
    // Highest set bit of the mask marks the sign bit of the access.
    top_mask = bit_mask ^ (bit_mask >> 1);

    rdata = r_shift & bit_mask;
    if (sext && |(r_shift & top_mask)) begin
      rdata = rdata | ~bit_mask;
    end
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit between execute and the data-memory bus.
//   req_*  : one request at a time, accepted on req_valid & req_ready
//   flush  : cancels the response of the request in flight
//   rsp_*  : one-cycle response pulse, rsp_rdata held until the next response
//   mem_*  : beat bus, mem_valid held with stable address/data until mem_ready
//   dbg_state : current FSM state
// Handshakes: a transfer happens on a cycle where valid and ready are both 1;
// once valid is raised its payload is stable and it stays high until that
// transfer (only rst may withdraw a bus beat).
module lsu_split
  import lsu_split_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_fault,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output state_t              dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  state_t state, state_next;

  logic              store_q, signed_q, cancel_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, beat0_q, beat1_q, held_q;

  logic              accept, is_fault, rsp_live;
  logic [2:0]        off_sel;
  logic [1:0]        size_sel;
  logic              straddle;
  logic [STRB_W-1:0] strb0, strb1;
  logic [DATA_W-1:0] wdata0, wdata1, merged;
  logic [ADDR_W-1:0] base_addr;

  assign accept = req_valid & req_ready;

  // In IDLE the steering logic looks at the incoming request so the fault
  // decision can be made at acceptance; afterwards it uses the latched copy.
  assign off_sel  = (state == ST_IDLE) ? 3'(req_addr[OFF_W-1:0]) : 3'(addr_q[OFF_W-1:0]);
  assign size_sel = (state == ST_IDLE) ? req_size : size_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .off      (off_sel),
    .size     (size_sel),
    .sext     (signed_q),
    .wdata    (wdata_q),
    .b0       (beat0_q),
    .b1       (beat1_q),
    .straddle (straddle),
    .strb0    (strb0),
    .strb1    (strb1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .rdata    (merged)
  );

  assign is_fault = (req_size == SZ_D && DATA_W == 32) || (straddle && !ALLOW_MISALIGNED);
  assign base_addr = addr_q & ~ADDR_W'(STRB_W - 1);
  // A flush seen at any point after acceptance, or in the response cycle
  // itself, silences the response.
  assign rsp_live  = ~cancel_q & ~flush;
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (flush)         state_next = ST_IDLE;
          else if (is_fault) state_next = ST_FAULT;
          else               state_next = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        // A flush before the first handshake completes means no second beat.
        if (mem_ready) state_next = (straddle && !cancel_q && !flush) ? ST_BEAT1 : ST_RESP;
      end
      ST_BEAT1: begin
        if (mem_ready) state_next = ST_RESP;
      end
      ST_RESP:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = base_addr;
    mem_wdata = wdata0;
    mem_wstrb = '0;
    rsp_valid = 1'b0;
    rsp_fault = 1'b0;
    rsp_rdata = held_q;
    case (state)
      ST_IDLE: req_ready = ~rst;
      ST_BEAT0: begin
        mem_valid = 1'b1;
        mem_wstrb = store_q ? strb0 : '0;
      end
      ST_BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = base_addr + ADDR_W'(STRB_W);
        mem_wdata = wdata1;
        mem_wstrb = store_q ? strb1 : '0;
      end
      ST_RESP: begin
        rsp_valid = rsp_live;
        if (rsp_live) rsp_rdata = store_q ? '0 : merged;
      end
      ST_FAULT: begin
        rsp_valid = rsp_live;
        rsp_fault = rsp_live;
        if (rsp_live) rsp_rdata = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      cancel_q <= 1'b0;
      size_q   <= SZ_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      beat0_q  <= '0;
      beat1_q  <= '0;
      held_q   <= '0;
    end else begin
      if (accept) begin
        store_q  <= req_store;
        signed_q <= req_signed;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        cancel_q <= 1'b0;
      end else if (state != ST_IDLE && flush) begin
        cancel_q <= 1'b1;
      end
      if (state == ST_BEAT0 && mem_ready) beat0_q <= mem_rdata;
      if (state == ST_BEAT1 && mem_ready) beat1_q <= mem_rdata;
      if (state == ST_RESP && rsp_live)   held_q  <= store_q ? '0 : merged;
      if (state == ST_FAULT && rsp_live)  held_q  <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
module tb_lsu_split;
  import lsu_split_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_valid_na, req_store, req_signed, flush, mem_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;

  logic        req_ready, rsp_valid, rsp_fault, mem_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  state_t      dbg_state;

  logic        na_req_ready, na_rsp_valid, na_rsp_fault, na_mem_valid;
  logic [31:0] na_rsp_rdata, na_mem_addr, na_mem_wdata;
  logic [3:0]  na_mem_wstrb;
  state_t      na_dbg_state;

  lsu_split #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .dbg_state(dbg_state)
  );

  lsu_split #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
    .clk(clk), .rst(rst), .req_valid(req_valid_na), .req_ready(na_req_ready),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata), .rsp_fault(na_rsp_fault),
    .mem_valid(na_mem_valid), .mem_ready(mem_ready), .mem_addr(na_mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(na_mem_wdata), .mem_wstrb(na_mem_wstrb),
    .dbg_state(na_dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] bus_mem [logic [31:0]];  // memory seen/modified by the DUT
  logic [7:0] mdl_mem [logic [31:0]];  // reference memory

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
  endfunction

  // Reference load: gather n little-endian bytes then extend.
  function automatic logic [31:0] mdl_load(input logic [31:0] a, input int n, input logic sg);
    logic [31:0] v, mask;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl_rd(a + 32'(i))) << (8 * i));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    if (sg && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] strb_bits(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // ---------------- driver + bus responder ----------------
  bit          r_got, r_flt, r_done;
  int          r_lat, r_nb;
  logic [31:0] r_rd;
  logic [31:0] r_ba [2];
  logic [3:0]  r_bs [2];
  logic [31:0] r_bw [2];

  // Issues one request, serves its bus beats with 'stall' wait cycles each,
  // pulses flush at cycle flush_at after acceptance (0 = acceptance cycle).
  task automatic xact(input bit na, input logic st, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd, input int stall,
                      input int flush_at);
    bit pend;
    int wait_cnt;
    logic [31:0] pa, pw, ma, mwd, rdd, word;
    logic [3:0]  ps, ms;
    logic        mv, rv, rf, rr;
    r_got = 0; r_flt = 0; r_done = 0; r_lat = 0; r_nb = 0; r_rd = 0;
    req_store = st; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    if (na) req_valid_na = 1'b1; else req_valid = 1'b1;
    flush = (flush_at == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid_na = 1'b0; flush = 1'b0;
    pend = 0; wait_cnt = 0;
    for (int k = 1; k <= 60 && !r_done; k++) begin
      flush = (k == flush_at);
      #1;
      mv  = na ? na_mem_valid : mem_valid;
      ma  = na ? na_mem_addr  : mem_addr;
      ms  = na ? na_mem_wstrb : mem_wstrb;
      mwd = na ? na_mem_wdata : mem_wdata;
      rv  = na ? na_rsp_valid : rsp_valid;
      rf  = na ? na_rsp_fault : rsp_fault;
      rdd = na ? na_rsp_rdata : rsp_rdata;
      rr  = na ? na_req_ready : req_ready;
      if (rr) begin
        r_done = 1;
      end else begin
        if (rv) begin
          if (r_got) chk("single_rsp", 32'(rv), 32'd0);
          r_got = 1; r_rd = rdd; r_flt = rf; r_lat = k;
        end
        if (pend) chk("beat_held", 32'(mv), 32'd1);
        if (mv) begin
          if (!pend) begin
            pend = 1; wait_cnt = 0; pa = ma; ps = ms; pw = mwd;
            if (r_nb < 2) begin r_ba[r_nb] = ma; r_bs[r_nb] = ms; r_bw[r_nb] = mwd; end
            r_nb++;
          end else begin
            chk("hold_addr", ma, pa);
            chk("hold_strb", 32'(ms), 32'(ps));
            chk("hold_wdata", mwd, pw);
          end
          if (wait_cnt == stall) begin
            for (int i = 0; i < 4; i++) word[8*i +: 8] = bus_rd(ma + 32'(i));
            for (int i = 0; i < 4; i++) if (ms[i]) bus_mem[ma + 32'(i)] = mwd[8*i +: 8];
            mem_rdata = word; mem_ready = 1'b1; pend = 0;
          end else begin
            mem_ready = 1'b0; wait_cnt++;
          end
        end else begin
          mem_ready = 1'b0;
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
    end
    flush = 1'b0;
    if (!r_done) begin
      total++; bad++;
      $display("FAIL timeout: unit did not return to idle for addr %h", ad);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          na;
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad, wd, mw;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] w0m;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] w1m;
    logic [31:0] rd;
    logic        flt;
    int          lat;
  } vec_t;

  vec_t vt [11];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        st, sg, strad;
    logic [1:0]  sz;
    logic [31:0] ad, wd, exp_rd, act_b, exp_b;
    int          n, stall, nb;

    rst = 1'b1; req_valid = 0; req_valid_na = 0; req_store = 0; req_size = 0;
    req_signed = 0; req_addr = 0; req_wdata = 0; flush = 0; mem_ready = 0; mem_rdata = 0;

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_state_na", 32'(na_dbg_state), 32'(ST_IDLE));

    // ---- table-driven vectors (no stalls) ----
    //       na st sz    sg  addr          wdata         mem word      nb a0            s0    w0m           a1            s1    w1m           rdata         flt lat
    vt[0]  = '{0, 0, SZ_W, 1, 32'h0000_0104, 32'h0,        32'h80F0_1234, 1, 32'h0000_0104, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h80F0_1234, 0, 2};
    vt[1]  = '{0, 0, SZ_B, 1, 32'h0000_0203, 32'h0,        32'h9A00_0000, 1, 32'h0000_0200, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_FF9A, 0, 2};
    vt[2]  = '{0, 0, SZ_B, 0, 32'h0000_0203, 32'h0,        32'h9A00_0000, 1, 32'h0000_0200, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_009A, 0, 2};
    vt[3]  = '{0, 1, SZ_W, 0, 32'h0000_0106, 32'hAABB_CCDD, 32'h0,        2, 32'h0000_0104, 4'hC, 32'hCCDD_0000, 32'h0000_0108, 4'h3, 32'h0000_AABB, 32'h0,        0, 3};
    vt[4]  = '{1, 0, SZ_H, 0, 32'h0000_00FF, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1};
    vt[5]  = '{0, 0, SZ_D, 0, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1};
    vt[6]  = '{0, 0, SZ_H, 1, 32'h0000_0102, 32'h0,        32'h8001_7777, 1, 32'h0000_0100, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_8001, 0, 2};
    vt[7]  = '{0, 1, SZ_B, 0, 32'h0000_0101, 32'h0000_0055, 32'h0,        1, 32'h0000_0100, 4'h2, 32'h0000_5500, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2};
    vt[8]  = '{1, 0, SZ_W, 0, 32'h0000_0300, 32'h0,        32'h1234_5678, 1, 32'h0000_0300, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h1234_5678, 0, 2};
    vt[9]  = '{1, 1, SZ_B, 0, 32'h0000_03FF, 32'h0000_007E, 32'h0,        1, 32'h0000_03FC, 4'h8, 32'h7E00_0000, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2};
    vt[10] = '{1, 0, SZ_W, 0, 32'h0000_0106, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1};

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 4; i++) bus_mem[(vt[v].ad & ~32'h3) + 32'(i)] = vt[v].mw[8*i +: 8];
      xact(vt[v].na, vt[v].st, vt[v].sz, vt[v].sg, vt[v].ad, vt[v].wd, 0, -1);
      chk($sformatf("v%0d_beats", v), 32'(r_nb), 32'(vt[v].nb));
      chk($sformatf("v%0d_rsp_seen", v), 32'(r_got), 32'd1);
      chk($sformatf("v%0d_rdata", v), r_rd, vt[v].rd);
      chk($sformatf("v%0d_fault", v), 32'(r_flt), 32'(vt[v].flt));
      chk($sformatf("v%0d_latency", v), 32'(r_lat), 32'(vt[v].lat));
      if (vt[v].nb > 0 && r_nb > 0) begin
        chk($sformatf("v%0d_addr0", v), r_ba[0], vt[v].a0);
        chk($sformatf("v%0d_strb0", v), 32'(r_bs[0]), 32'(vt[v].s0));
        if (vt[v].st) chk($sformatf("v%0d_wdata0", v), r_bw[0] & strb_bits(vt[v].s0), vt[v].w0m);
      end
      if (vt[v].nb > 1 && r_nb > 1) begin
        chk($sformatf("v%0d_addr1", v), r_ba[1], vt[v].a1);
        chk($sformatf("v%0d_strb1", v), 32'(r_bs[1]), 32'(vt[v].s1));
        if (vt[v].st) chk($sformatf("v%0d_wdata1", v), r_bw[1] & strb_bits(vt[v].s1), vt[v].w1m);
      end
    end

    // ---- split load across the top of the address space, stalled beats ----
    xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF_FFFE, 32'h0, 3, -1);
    chk("wrap_beats", 32'(r_nb), 32'd2);
    chk("wrap_addr0", r_ba[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", r_ba[1], 32'h0000_0000);
    chk("wrap_rdata", r_rd, mdl_load(32'hFFFF_FFFE, 4, 1'b0));
    chk("wrap_latency", 32'(r_lat), 32'd9);

    // ---- flush during stalled BEAT0 of a split store ----
    xact(0, 1'b1, SZ_W, 1'b0, 32'h0000_0406, 32'h1122_3344, 3, 2);
    chk("flb0_beats", 32'(r_nb), 32'd1);
    chk("flb0_rsp", 32'(r_got), 32'd0);
    chk("flb0_idle", 32'(r_done), 32'd1);
    chk("flb0_written", 32'(bus_rd(32'h0000_0406)), 32'h44);
    chk("flb0_untouched", 32'(bus_rd(32'h0000_0408)), 32'(dflt(32'h0000_0408)));

    // ---- flush in the acceptance cycle ----
    xact(0, 1'b0, SZ_W, 1'b0, 32'h0000_0500, 32'h0, 0, 0);
    chk("flacc_beats", 32'(r_nb), 32'd0);
    chk("flacc_rsp", 32'(r_got), 32'd0);
    chk("flacc_idle", 32'(r_done), 32'd1);

    // ---- flush in the response cycle ----
    xact(0, 1'b0, SZ_W, 1'b0, 32'h0000_0504, 32'h0, 0, 2);
    chk("flrsp_beats", 32'(r_nb), 32'd1);
    chk("flrsp_rsp", 32'(r_got), 32'd0);

    // ---- flush in the fault cycle ----
    xact(0, 1'b0, SZ_D, 1'b0, 32'h0000_0508, 32'h0, 0, 1);
    chk("flflt_rsp", 32'(r_got), 32'd0);

    // ---- randomized traffic against the reference memory ----
    for (int t = 0; t < 150; t++) begin
      st    = 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 3));
      sg    = 1'($urandom_range(0, 1));
      ad    = 32'h0000_1000 + 32'($urandom_range(0, 47));
      wd    = $urandom;
      stall = $urandom_range(0, 2);
      n     = 1 << sz;
      strad = (int'(ad % 4) + n) > 4;
      xact(0, st, sz, sg, ad, wd, stall, -1);
      chk("rnd_rsp_seen", 32'(r_got), 32'd1);
      if (sz == SZ_D) begin
        chk("rnd_fault", 32'(r_flt), 32'd1);
        chk("rnd_fault_beats", 32'(r_nb), 32'd0);
        chk("rnd_fault_rdata", r_rd, 32'd0);
        chk("rnd_fault_lat", 32'(r_lat), 32'd1);
      end else begin
        nb = strad ? 2 : 1;
        exp_rd = st ? 32'd0 : mdl_load(ad, n, sg);
        if (st) for (int i = 0; i < n; i++) mdl_mem[ad + 32'(i)] = wd[8*i +: 8];
        chk("rnd_fault", 32'(r_flt), 32'd0);
        chk("rnd_beats", 32'(r_nb), 32'(nb));
        chk("rnd_rdata", r_rd, exp_rd);
        chk("rnd_lat", 32'(r_lat), 32'(1 + nb * (1 + stall)));
        if (r_nb > 0) begin
          chk("rnd_addr0", r_ba[0], ad & ~32'h3);
          if (!st) chk("rnd_load_strb", 32'(r_bs[0]), 32'd0);
        end
        if (nb == 2 && r_nb == 2) chk("rnd_addr1", r_ba[1], (ad & ~32'h3) + 32'd4);
        if (st) begin
          act_b = 0; exp_b = 0;
          for (int i = 0; i < n; i++) begin
            act_b[8*i +: 8] = bus_rd(ad + 32'(i));
            exp_b[8*i +: 8] = mdl_rd(ad + 32'(i));
          end
          chk("rnd_store_mem", act_b, exp_b);
        end
      end
    end

    // ---- reset while BEAT1 is pending ----
    req_store = 1'b0; req_size = SZ_W; req_signed = 1'b0;
    req_addr = 32'h0000_0606; req_wdata = 0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    chk("rstb1_valid_before", 32'(mem_valid), 32'd1);
    chk("rstb1_addr_before", mem_addr, 32'h0000_0608);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstb1_valid_after", 32'(mem_valid), 32'd0);
    chk("rstb1_ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstb1_ready", 32'(req_ready), 32'd1);
    chk("rstb1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstb1_rdata", rsp_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
